// File: rtl/seven_segment_arbiter.sv
// Four-way round-robin arbiter in front of an 8-digit seven-segment display.
// The owner keeps the display for MAX_HOLD strobe ticks, after which any other
// requester may take over. One blank cycle (SWITCH) separates owners.
// All outputs are registered. num_out/dots_out trail gnt by one cycle.
module seven_segment_arbiter #(
  parameter int W        = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] num_in,
  input  logic [31:0]    dots_in,
  output logic [3:0]     gnt,
  output logic [W-1:0]   num_out,
  output logic [7:0]     dots_out,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t       state_q, state_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [7:0]   hold_cnt_q, hold_cnt_d;
  logic [3:0]   gnt_q, gnt_d;
  logic [W-1:0] num_out_q, num_out_d;
  logic [7:0]   dots_out_q, dots_out_d;
  logic         busy_q, busy_d;

  // Requests rotated so that bit 0 is the requester just after ptr.
  logic [3:0]   req_rot;
  logic [1:0]   pick_off;
  logic [1:0]   pick;
  logic [3:0]   owner_oh;
  logic [3:0]   others_req;
  logic         hold_full;

  // Per-requester data slices, muxed by owner below.
  logic [W-1:0] num_slice  [4];
  logic [7:0]   dots_slice [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_slices
    assign num_slice[gi]  = num_in[gi*W +: W];
    assign dots_slice[gi] = dots_in[gi*8 +: 8];
    assign req_rot[gi]    = req[2'(ptr_q + 2'(gi + 1))];
  end

  // First set request scanning ptr+1, ptr+2, ptr+3, ptr (the last owner goes last).
  always_comb begin
    pick_off = 2'd3;
    if (req_rot[0])      pick_off = 2'd0;
    else if (req_rot[1]) pick_off = 2'd1;
    else if (req_rot[2]) pick_off = 2'd2;
    pick = ptr_q + pick_off + 2'd1;
  end

  assign owner_oh   = 4'b0001 << owner_q;
  assign others_req = req & ~owner_oh;
  assign hold_full  = (hold_cnt_q == HOLD_MAX);

  // State and output registers; reset wins over every input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd3;
      hold_cnt_q <= 8'd0;
      gnt_q      <= 4'b0000;
      num_out_q  <= '0;
      dots_out_q <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      num_out_q  <= num_out_d;
      dots_out_q <= dots_out_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: grant, hold counting, release/preempt, one-cycle gap.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = OWN;
          owner_d    = pick;
          hold_cnt_d = 8'd0;
        end
      end
      OWN: begin
        // Release and preempt collapse into a single SWITCH entry.
        if (!req[owner_q] || (hold_full && |others_req)) begin
          state_d = SWITCH;
          ptr_d   = owner_q;
        end else if (en && !hold_full) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      SWITCH: begin
        if (|req) begin
          state_d    = OWN;
          owner_d    = pick;
          hold_cnt_d = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values: gnt tracks the coming state, data tracks the current one.
  always_comb begin
    gnt_d      = (state_d == OWN) ? (4'b0001 << owner_d) : 4'b0000;
    busy_d     = (state_d != IDLE);
    num_out_d  = '0;
    dots_out_d = 8'd0;
    if (state_q == OWN) begin
      num_out_d  = num_slice[owner_q];
      dots_out_d = dots_slice[owner_q];
    end
  end

  assign gnt      = gnt_q;
  assign num_out  = num_out_q;
  assign dots_out = dots_out_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_seven_segment_arbiter.sv
// Directed bench: each step drives one cycle of inputs and queues the outputs
// expected after the following clock edge; a monitor pops and compares them.
module tb_seven_segment_arbiter;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [3:0]     req = 4'b0000;
  logic [4*W-1:0] num_in = '0;
  logic [31:0]    dots_in = '0;
  logic [3:0]     gnt;
  logic [W-1:0]   num_out;
  logic [7:0]     dots_out;
  logic           busy;

  seven_segment_arbiter #(.W(W), .MAX_HOLD(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .num_in   (num_in),
    .dots_in  (dots_in),
    .gnt      (gnt),
    .num_out  (num_out),
    .dots_out (dots_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   gnt;
    logic [W-1:0] num;
    logic [7:0]   dots;
    logic         busy;
    string        tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       mx;
  int         total = 0;
  int         bad = 0;
  int         pushed = 0;
  logic [W-1:0] nums [4];
  logic [7:0]   dots [4];

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  // Drive one cycle; esrc < 0 means blank data expected, else that requester's data.
  task automatic step(input string tag, input logic r, input logic [3:0] rq, input logic e,
                      input logic [3:0] eg, input int esrc, input logic eb);
    exp_t x;
    rst_n = r;
    req   = rq;
    en    = e;
    for (int i = 0; i < 4; i++) begin
      num_in[i*W +: W]  = nums[i];
      dots_in[i*8 +: 8] = dots[i];
    end
    x.gnt  = eg;
    x.busy = eb;
    x.tag  = tag;
    if (esrc < 0) begin
      x.num  = '0;
      x.dots = 8'd0;
    end else begin
      x.num  = nums[esrc];
      x.dots = dots[esrc];
    end
    sb.push_back(x);
    pushed++;
    @(negedge clk);
    #1;
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      total++;
      if (gnt !== mx.gnt || num_out !== mx.num || dots_out !== mx.dots || busy !== mx.busy) begin
        bad++;
        $display("FAIL %s: got gnt=%b num=%h dots=%h busy=%b, want gnt=%b num=%h dots=%h busy=%b",
                 mx.tag, gnt, num_out, dots_out, busy, mx.gnt, mx.num, mx.dots, mx.busy);
      end else begin
        $display("ok   %s: gnt=%b num=%h dots=%h busy=%b", mx.tag, gnt, num_out, dots_out, busy);
      end
    end
  end

  initial begin
    nums[0] = 32'h1111_0000; dots[0] = 8'h01;
    nums[1] = 32'h2222_1111; dots[1] = 8'h02;
    nums[2] = 32'h1234_5678; dots[2] = 8'h04;
    nums[3] = 32'h3333_3333; dots[3] = 8'h80;
    @(negedge clk);
    #1;

    // Reset state
    step("rst0", 1'b0, 4'b0000, 1'b0, 4'b0000, -1, 1'b0);
    step("rst1", 1'b0, 4'b0000, 1'b1, 4'b0000, -1, 1'b0);

    // Single request from requester 2
    step("single_gnt",  1'b1, 4'b0100, 1'b0, 4'b0100, -1, 1'b1);
    step("single_num",  1'b1, 4'b0100, 1'b0, 4'b0100,  2, 1'b1);
    step("single_hold", 1'b1, 4'b0100, 1'b1, 4'b0100,  2, 1'b1);
    step("single_rel",  1'b1, 4'b0000, 1'b0, 4'b0000,  2, 1'b1);
    step("single_idle", 1'b1, 4'b0000, 1'b0, 4'b0000, -1, 1'b0);

    // Reset beats req/en; en in IDLE must not count
    step("rot_rst", 1'b0, 4'b1111, 1'b1, 4'b0000, -1, 1'b0);
    step("idle_en", 1'b1, 4'b0000, 1'b1, 4'b0000, -1, 1'b0);

    // All four request with en every cycle: 5 grant cycles, 1 gap, rotate
    for (int i = 0; i < 4; i++) begin
      step($sformatf("rot%0d_gnt", i), 1'b1, 4'b1111, 1'b1, oh(i), -1, 1'b1);
      for (int k = 0; k < 4; k++)
        step($sformatf("rot%0d_own%0d", i, k), 1'b1, 4'b1111, 1'b1, oh(i), i, 1'b1);
      step($sformatf("rot%0d_sw", i), 1'b1, 4'b1111, 1'b1, 4'b0000, i, 1'b1);
    end
    step("rot_idle", 1'b1, 4'b0000, 1'b0, 4'b0000, -1, 1'b0);

    // Requester 1: data updates pass through, non-owner changes ignored, then release
    step("rel_gnt", 1'b1, 4'b0010, 1'b0, 4'b0010, -1, 1'b1);
    step("rel_num", 1'b1, 4'b0010, 1'b0, 4'b0010,  1, 1'b1);
    nums[1] = 32'hCAFE_BABE; dots[1] = 8'h5A;
    nums[0] = 32'hDEAD_BEEF; dots[0] = 8'hFF;
    step("rel_upd",  1'b1, 4'b0010, 1'b0, 4'b0010,  1, 1'b1);
    step("rel_sw",   1'b1, 4'b0000, 1'b0, 4'b0000,  1, 1'b1);
    step("rel_idle", 1'b1, 4'b0000, 1'b0, 4'b0000, -1, 1'b0);

    // Sole requester 0 over 20 ticks keeps the grant; then 1 joins
    step("sole_gnt", 1'b1, 4'b0001, 1'b1, 4'b0001, -1, 1'b1);
    for (int k = 0; k < 20; k++)
      step($sformatf("sole_own%0d", k), 1'b1, 4'b0001, 1'b1, 4'b0001, 0, 1'b1);
    step("sole_sw",   1'b1, 4'b0011, 1'b0, 4'b0000,  0, 1'b1);
    step("sole_next", 1'b1, 4'b0011, 1'b0, 4'b0010, -1, 1'b1);
    step("sole_nnum", 1'b1, 4'b0011, 1'b0, 4'b0010,  1, 1'b1);

    // Reset while requester 2 owns the display
    step("mid_sw",   1'b1, 4'b0100, 1'b0, 4'b0000,  1, 1'b1);
    step("mid_gnt",  1'b1, 4'b0100, 1'b0, 4'b0100, -1, 1'b1);
    step("mid_num",  1'b1, 4'b0100, 1'b1, 4'b0100,  2, 1'b1);
    step("mid_rst",  1'b0, 4'b0100, 1'b1, 4'b0000, -1, 1'b0);
    step("mid_back", 1'b1, 4'b0100, 1'b0, 4'b0100, -1, 1'b1);
    step("mid_num2", 1'b1, 4'b0100, 1'b0, 4'b0100,  2, 1'b1);

    // After reset the scan starts at requester 0 (1 beats 3)
    step("ptr_rst", 1'b0, 4'b1010, 1'b0, 4'b0000, -1, 1'b0);
    step("ptr_gnt", 1'b1, 4'b1010, 1'b0, 4'b0010, -1, 1'b1);
    step("ptr_num", 1'b1, 4'b1010, 1'b0, 4'b0010,  1, 1'b1);

    // Every queued expectation must have been checked
    total++;
    if (sb.size() != 0 || total != pushed + 1) begin
      bad++;
      $display("FAIL drain: got %0d checked with %0d left, want %0d checked with 0 left",
               total - 1, sb.size(), pushed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
